// File: rtl/fios_result_collector_4a.sv
// fios_result_collector_4a
// ------------------------
// Sits at the far end of the DSP cascade chain of the FIOS Montgomery
// multiplier. It takes the unnormalised 34-bit P word of the last DSP slice,
// one word per cycle with the least significant word first. It folds the
// running carry into each word, which splits the word into a 17-bit digit
// and an 18-bit carry. After S digits it presents the assembled result to
// the consumer through a valid/ready handshake.
//
// Ports:
//   clock_i      rising-edge clock for all state
//   reset_i      synchronous active-high reset, highest priority
//   P_i          34-bit P output of the last DSP slice
//   valid_i      P_i carries a result word this cycle
//   last_i       marks the word that should be digit S-1
//   ready_o      collector accepts a word this cycle (low in HOLD)
//   res_o        assembled result, digit 0 in bits [16:0]
//   carry_o      residual carry above digit S-1
//   res_valid_o  res_o/carry_o hold a completed result
//   res_ready_i  consumer takes the result
//   err_o        sticky protocol error flag (cleared only by reset)

module fios_result_collector_4a #(
  parameter int S       = 16,
  parameter int DIGIT_W = 17
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic [33:0]            P_i,
  input  logic                   valid_i,
  input  logic                   last_i,
  output logic                   ready_o,
  output logic [DIGIT_W*S-1:0]   res_o,
  output logic [17:0]            carry_o,
  output logic                   res_valid_o,
  input  logic                   res_ready_i,
  output logic                   err_o
);

  localparam int RES_W = DIGIT_W * S;
  localparam int CNT_W = (S > 1) ? $clog2(S) : 1;

  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [17:0]        carry_reg;
  logic [RES_W-1:0]   shift_reg;

  logic [34:0]        sum;
  logic [DIGIT_W-1:0] digit;
  logic [17:0]        carry_next;
  logic [RES_W-1:0]   shifted;
  logic               at_last;

  // Fold the running carry into the incoming word. The 35-bit sum cannot
  // overflow: (2^34-1) + (2^18-1) < 2^35.
  assign sum        = {1'b0, P_i} + {17'b0, carry_reg};
  assign digit      = sum[DIGIT_W-1:0];
  assign carry_next = sum[34:17];
  assign at_last    = (count == CNT_W'(S - 1));

  // New digits enter at the top and move down. After S accepts, digit 0
  // ends up in the least significant slot.
  generate
    if (S == 1) begin : g_single
      assign shifted = digit;
    end else begin : g_multi
      assign shifted = {digit, shift_reg[RES_W-1:DIGIT_W]};
    end
  endgenerate

  // Control and datapath state. res_o/carry_o are a separate holding register.
  // They load only on completion, so a discarded or in-progress burst never
  // disturbs the last delivered result.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state       <= IDLE;
      ready_o     <= 1'b1;
      res_valid_o <= 1'b0;
      res_o       <= '0;
      carry_o     <= '0;
      err_o       <= 1'b0;
      count       <= '0;
      carry_reg   <= '0;
      shift_reg   <= '0;
    end else begin
      case (state)
        IDLE, COLLECT: begin
          if (valid_i) begin
            if (last_i && !at_last) begin
              // Burst ended too early: drop it and start over.
              err_o     <= 1'b1;
              count     <= '0;
              carry_reg <= '0;
              state     <= IDLE;
            end else if (at_last) begin
              // A missing last_i still completes the burst, but it is flagged.
              if (!last_i) err_o <= 1'b1;
              res_o       <= shifted;
              carry_o     <= carry_next;
              count       <= '0;
              carry_reg   <= '0;
              state       <= HOLD;
              ready_o     <= 1'b0;
              res_valid_o <= 1'b1;
            end else begin
              shift_reg <= shifted;
              carry_reg <= carry_next;
              count     <= count + CNT_W'(1);
              state     <= COLLECT;
            end
          end
        end
        HOLD: begin
          // Words offered while not ready are dropped and flagged.
          if (valid_i) err_o <= 1'b1;
          if (res_ready_i) begin
            state       <= IDLE;
            ready_o     <= 1'b1;
            res_valid_o <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          ready_o     <= 1'b1;
          res_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fios_result_collector_4a.sv
// Testbench for fios_result_collector_4a with S=4.
// The reference treats a burst as one big integer, sum(P_k * 2^(17k)).
// The expected result is that integer modulo 2^(17S), and the expected carry
// is the part above 2^(17S).

module tb_fios_result_collector_4a;

  localparam int S  = 4;
  localparam int RW = 17 * S;

  logic          clock_i = 1'b0;
  logic          reset_i = 1'b0;
  logic [33:0]   P_i = '0;
  logic          valid_i = 1'b0;
  logic          last_i = 1'b0;
  logic          ready_o;
  logic [RW-1:0] res_o;
  logic [17:0]   carry_o;
  logic          res_valid_o;
  logic          res_ready_i = 1'b0;
  logic          err_o;

  int vectors = 0;
  int miscompares = 0;
  logic exp_err = 1'b0;
  logic [RW-1:0] exp_res = '0;
  logic [17:0]   exp_carry = '0;

  fios_result_collector_4a #(.S(S)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .P_i(P_i), .valid_i(valid_i),
    .last_i(last_i), .ready_o(ready_o), .res_o(res_o), .carry_o(carry_o),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .err_o(err_o)
  );

  always #5 clock_i = ~clock_i;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [127:0] ref_total(input logic [33:0] w [S]);
    logic [127:0] t;
    t = '0;
    for (int k = 0; k < S; k++) t = t + (128'(w[k]) << (17 * k));
    return t;
  endfunction

  task automatic set_expect(input logic [33:0] w [S]);
    logic [127:0] t;
    t = ref_total(w);
    exp_res   = t[RW-1:0];
    exp_carry = t[RW+17:RW];
  endtask

  task automatic drive_word(input logic [33:0] p, input logic l);
    @(negedge clock_i);
    valid_i = 1'b1;
    P_i     = p;
    last_i  = l;
  endtask

  // Sends S words with optional bubbles. On return it is the negedge right
  // after the final accept, with the bus idle.
  task automatic send_burst(input logic [33:0] w [S], input int gap,
                            input bit rand_gap, input bit mark_last);
    int g;
    for (int k = 0; k < S; k++) begin
      drive_word(w[k], mark_last && (k == S - 1));
      if (k < S - 1) begin
        g = rand_gap ? int'($urandom_range(0, gap)) : gap;
        for (int b = 0; b < g; b++) begin
          @(negedge clock_i);
          valid_i = 1'b0;
          last_i  = 1'b0;
        end
      end
    end
    @(negedge clock_i);
    valid_i = 1'b0;
    last_i  = 1'b0;
  endtask

  task automatic handshake();
    res_ready_i = 1'b1;
    @(negedge clock_i);
    res_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    repeat (2) @(negedge clock_i);
    reset_i = 1'b0;
    exp_err = 1'b0;
    vectors++;
    if (res_o !== '0 || carry_o !== '0 || res_valid_o !== 1'b0 ||
        err_o !== 1'b0 || ready_o !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset: res=%h carry=%h rv=%b err=%b rdy=%b, expected zeros with ready=1",
               res_o, carry_o, res_valid_o, err_o, ready_o);
    end
  endtask

  task automatic test_basic();
    logic [33:0] w [S];
    w[0] = 34'h1FFFF; w[1] = 34'h1; w[2] = 34'h0; w[3] = 34'h0;
    set_expect(w);
    send_burst(w, 0, 1'b0, 1'b1);
    vectors++;
    if (res_valid_o !== 1'b1 || ready_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL basic_latency: rv=%b rdy=%b, expected rv=1 rdy=0", res_valid_o, ready_o);
    end
    vectors++;
    if (res_o !== {17'h0, 17'h0, 17'h1, 17'h1FFFF} || carry_o !== 18'h0 || err_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL basic_result: res=%h carry=%h err=%b, expected res=%h carry=0 err=0",
               res_o, carry_o, err_o, {17'h0, 17'h0, 17'h1, 17'h1FFFF});
    end
    handshake();
    vectors++;
    if (res_valid_o !== 1'b0 || ready_o !== 1'b1 || res_o !== exp_res) begin
      miscompares++;
      $display("[TB] FAIL basic_release: rv=%b rdy=%b res=%h, expected rv=0 rdy=1 res=%h",
               res_valid_o, ready_o, res_o, exp_res);
    end
  endtask

  task automatic test_max_words();
    logic [33:0] w [S];
    for (int k = 0; k < S; k++) w[k] = 34'h3_FFFF_FFFF;
    set_expect(w);
    send_burst(w, 0, 1'b0, 1'b1);
    vectors++;
    if (res_valid_o !== 1'b1 || res_o !== exp_res || carry_o !== exp_carry || err_o !== exp_err) begin
      miscompares++;
      $display("[TB] FAIL max_words: rv=%b res=%h carry=%h err=%b, expected rv=1 res=%h carry=%h err=%b",
               res_valid_o, res_o, carry_o, err_o, exp_res, exp_carry, exp_err);
    end
    handshake();
  endtask

  task automatic test_bubbles();
    logic [33:0] w [S];
    w[0] = 34'h1FFFF; w[1] = 34'h1; w[2] = 34'h0; w[3] = 34'h0;
    set_expect(w);
    send_burst(w, 2, 1'b0, 1'b1);
    vectors++;
    if (res_valid_o !== 1'b1 || res_o !== exp_res || carry_o !== exp_carry || err_o !== exp_err) begin
      miscompares++;
      $display("[TB] FAIL bubbles: rv=%b res=%h carry=%h err=%b, expected rv=1 res=%h carry=%h err=%b",
               res_valid_o, res_o, carry_o, err_o, exp_res, exp_carry, exp_err);
    end
    handshake();
  endtask

  task automatic test_random();
    logic [33:0] w [S];
    for (int n = 0; n < 24; n++) begin
      for (int k = 0; k < S; k++) begin
        if ($urandom_range(0, 3) == 0) w[k] = 34'h3_FFFF_FFFF;
        else w[k] = {$urandom, $urandom}[33:0];
      end
      set_expect(w);
      send_burst(w, 3, 1'b1, 1'b1);
      vectors++;
      if (res_valid_o !== 1'b1 || res_o !== exp_res || carry_o !== exp_carry || err_o !== exp_err) begin
        miscompares++;
        $display("[TB] FAIL random_%0d: rv=%b res=%h carry=%h err=%b, expected rv=1 res=%h carry=%h err=%b",
                 n, res_valid_o, res_o, carry_o, err_o, exp_res, exp_carry, exp_err);
      end
      repeat ($urandom_range(0, 3)) @(negedge clock_i);
      handshake();
    end
  endtask

  task automatic test_missing_last();
    logic [33:0] w [S];
    for (int k = 0; k < S; k++) w[k] = 34'(k * 34'h12345 + 34'h777);
    set_expect(w);
    send_burst(w, 0, 1'b0, 1'b0);
    exp_err = 1'b1;
    vectors++;
    if (res_valid_o !== 1'b1 || res_o !== exp_res || carry_o !== exp_carry || err_o !== exp_err) begin
      miscompares++;
      $display("[TB] FAIL missing_last: rv=%b res=%h carry=%h err=%b, expected rv=1 res=%h carry=%h err=1",
               res_valid_o, res_o, carry_o, err_o, exp_res, exp_carry);
    end
    handshake();
  endtask

  task automatic test_early_last();
    logic [33:0] w [S];
    logic [RW-1:0] prev;
    prev = exp_res;
    drive_word(34'h2_0000_0001, 1'b0);
    drive_word(34'h1_2345_6789, 1'b1);
    @(negedge clock_i);
    valid_i = 1'b0;
    last_i  = 1'b0;
    exp_err = 1'b1;
    repeat (2) @(negedge clock_i);
    vectors++;
    if (err_o !== 1'b1 || res_valid_o !== 1'b0 || ready_o !== 1'b1 || res_o !== prev) begin
      miscompares++;
      $display("[TB] FAIL early_last: err=%b rv=%b rdy=%b res=%h, expected err=1 rv=0 rdy=1 res=%h",
               err_o, res_valid_o, ready_o, res_o, prev);
    end
    w[0] = 34'h0_0001_0000; w[1] = 34'h3_0000_0000; w[2] = 34'h5; w[3] = 34'h1_FFFF_FFFF;
    set_expect(w);
    send_burst(w, 0, 1'b0, 1'b1);
    vectors++;
    if (res_valid_o !== 1'b1 || res_o !== exp_res || carry_o !== exp_carry || err_o !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL early_last_recover: rv=%b res=%h carry=%h err=%b, expected rv=1 res=%h carry=%h err=1",
               res_valid_o, res_o, carry_o, err_o, exp_res, exp_carry);
    end
    handshake();
  endtask

  task automatic test_hold_backpressure();
    logic [33:0] w [S];
    for (int k = 0; k < S; k++) w[k] = 34'h2_AAAA_5555 >> k;
    set_expect(w);
    send_burst(w, 0, 1'b0, 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clock_i);
      valid_i = (c == 1);
      P_i     = 34'h3_1234_0000;
      vectors++;
      if (res_valid_o !== 1'b1 || ready_o !== 1'b0 || res_o !== exp_res || carry_o !== exp_carry) begin
        miscompares++;
        $display("[TB] FAIL hold_%0d: rv=%b rdy=%b res=%h carry=%h, expected rv=1 rdy=0 res=%h carry=%h",
                 c, res_valid_o, ready_o, res_o, carry_o, exp_res, exp_carry);
      end
    end
    valid_i = 1'b0;
    exp_err = 1'b1;
    vectors++;
    if (err_o !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL hold_err: err=%b, expected 1", err_o);
    end
    handshake();
    vectors++;
    if (res_valid_o !== 1'b0 || ready_o !== 1'b1 || res_o !== exp_res) begin
      miscompares++;
      $display("[TB] FAIL hold_release: rv=%b rdy=%b res=%h, expected rv=0 rdy=1 res=%h",
               res_valid_o, ready_o, res_o, exp_res);
    end
    for (int k = 0; k < S; k++) w[k] = 34'h1_0000_0003 + 34'(k);
    set_expect(w);
    send_burst(w, 0, 1'b0, 1'b1);
    vectors++;
    if (res_valid_o !== 1'b1 || res_o !== exp_res || carry_o !== exp_carry) begin
      miscompares++;
      $display("[TB] FAIL hold_next_burst: rv=%b res=%h carry=%h, expected rv=1 res=%h carry=%h",
               res_valid_o, res_o, carry_o, exp_res, exp_carry);
    end
    handshake();
  endtask

  task automatic test_reset_mid();
    logic [33:0] w [S];
    drive_word(34'h3_FFFF_FFFF, 1'b0);
    drive_word(34'h3_FFFF_FFFF, 1'b0);
    @(negedge clock_i);
    valid_i = 1'b0;
    reset_i = 1'b1;
    @(negedge clock_i);
    reset_i = 1'b0;
    exp_err = 1'b0;
    vectors++;
    if (res_o !== '0 || carry_o !== '0 || res_valid_o !== 1'b0 ||
        err_o !== 1'b0 || ready_o !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_mid: res=%h carry=%h rv=%b err=%b rdy=%b, expected zeros with ready=1",
               res_o, carry_o, res_valid_o, err_o, ready_o);
    end
    w[0] = 34'h5; w[1] = 34'h1_0000; w[2] = 34'h2_0002_0002; w[3] = 34'h7;
    set_expect(w);
    send_burst(w, 0, 1'b0, 1'b1);
    vectors++;
    if (res_valid_o !== 1'b1 || res_o !== exp_res || carry_o !== exp_carry || err_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_burst: rv=%b res=%h carry=%h err=%b, expected rv=1 res=%h carry=%h err=0",
               res_valid_o, res_o, carry_o, err_o, exp_res, exp_carry);
    end
    handshake();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max_words();
    test_bubbles();
    test_random();
    test_missing_last();
    test_early_last();
    test_hold_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
